dma_ahb_wr_master: RTL and testbench

// - DMA write-side AHB-Lite master: drains the DMA data FIFO and writes words to memory.
// - Takes one command (destination address + word count), pops one FIFO word per beat and

---
 rtl/dma_ahb_pkg.sv | 28 ++
 rtl/dma_ahb_wr_master.sv | 168 ++++++++++++++++
 tb/tb_dma_ahb_wr_master.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ahb_pkg.sv
// Shared definitions for the DMA AHB-Lite masters.
// Holds the AHB transfer encodings, the write-master state encoding and the
// address boundary that forces a new NONSEQ burst.
package dma_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HBURST_INCR = 3'b001;

  // An INCR burst may not cross a 1 KB boundary, so a beat landing on one restarts as NONSEQ.
  localparam int KB_BOUNDARY_BITS = 10;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] ST_ERR_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_ERR   = ST_ERR_ENC
  } wr_state_e;

endpackage

// File: rtl/dma_ahb_wr_master.sv
// DMA write-side AHB-Lite master.
// Accepts one command (destination address + word count), pops one FIFO word per
// beat and writes it to memory as an INCR burst of word transfers with pipelined
// address/data phases. Reports completion with done, an ERROR response with err.
//
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   cmd_valid/ready          command handshake (ready only while idle)
//   cmd_addr, cmd_words      destination byte address (word aligned), word count
//   fifo_empty, fifo_rd_en   FIFO status / pop strobe (data on fifo_rdata next cycle)
//   fifo_rdata               registered FIFO read data, stable until the next pop
//   HADDR..HWDATA            AHB-Lite master outputs
//   HREADY, HRESP            AHB-Lite slave response
//   busy, done, err          status: active, 1-cycle success pulse, 1-cycle abort pulse
module dma_ahb_wr_master
  import dma_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_words,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;     // address of the next beat to present
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;       // beats not yet accepted
  logic                  dp_q, dp_d;         // a data phase is outstanding
  logic                  seq_ok_q, seq_ok_d; // previous bus cycle accepted a beat of this burst
  logic                  done_q, done_d;

  logic cmd_fire;
  logic err_now;
  logic dp_ok;
  logic beat_avail;
  logic accept;

  // Address bits [1:0] are forced to zero; the inputs themselves are not needed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cmd_addr[1:0];

  assign cmd_fire = cmd_valid && (state_q == ST_IDLE);
  // First cycle of the two-cycle ERROR response.
  assign err_now  = dp_q && !HREADY && HRESP;
  assign dp_ok    = dp_q && HREADY && !HRESP;
  // A beat is presented only when it has data behind it. FIFO words can only
  // disappear through our own pop, so once presented the beat stays valid through
  // wait states and HTRANS/HADDR hold by construction.
  assign beat_avail = (state_q == ST_RUN) && (rem_q != '0) && !fifo_empty && !err_now;
  assign accept     = beat_avail && HREADY;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    dp_d     = dp_q;
    seq_ok_d = seq_ok_q;
    done_d   = 1'b0;
    HTRANS   = HTRANS_IDLE;

    if (beat_avail) begin
      HTRANS = (seq_ok_q && (addr_q[KB_BOUNDARY_BITS-1:0] != '0)) ? HTRANS_SEQ : HTRANS_NONSEQ;
    end

    // A data phase ends on any HREADY-high edge; a new one starts if a beat is accepted there.
    if (HREADY) begin
      dp_d = accept;
    end

    if (accept) begin
      addr_d   = addr_q + ADDR_WIDTH'(4);
      rem_d    = rem_q - CNT_WIDTH'(1);
      seq_ok_d = 1'b1;
    end else if (!beat_avail) begin
      // An IDLE cycle on the bus breaks the burst; the next beat restarts as NONSEQ.
      seq_ok_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d   = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          rem_d    = cmd_words;
          dp_d     = 1'b0;
          seq_ok_d = 1'b0;
          if (cmd_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (err_now) begin
          state_d = ST_ERR;
        end else if (accept && (rem_q == CNT_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (err_now) begin
          state_d = ST_ERR;
        end else if (dp_ok) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ERR: begin
        // Second ERROR cycle; the cancelled beat never gets a data phase.
        state_d = ST_IDLE;
        dp_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      dp_q     <= 1'b0;
      seq_ok_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      dp_q     <= dp_d;
      seq_ok_q <= seq_ok_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign err        = (state_q == ST_ERR);
  assign done       = done_q;
  assign fifo_rd_en = accept;
  assign HADDR      = addr_q;
  assign HWRITE     = 1'b1;
  assign HSIZE      = HSIZE_WORD;
  assign HBURST     = HBURST_INCR;
  // The FIFO holds its read data until the next pop, which only happens on the edge ending this data phase.
  assign HWDATA     = fifo_rdata;

endmodule

// File: tb/tb_dma_ahb_wr_master.sv
module tb_dma_ahb_wr_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [CW-1:0] cmd_words;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HRESP;
  logic          busy;
  logic          done;
  logic          err;

  dma_ahb_wr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .done(done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  int vectors = 0;
  int miscompares = 0;

  // FIFO environment
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pushed[$];   // words of the current command, in write order
  int next_push, refill_delay, cyc;
  bit trickle;

  // Reference model of the transfer, in bus-level terms
  bit            cmd_active, err_mode, done_now, dp_pend, gap;
  logic [AW-1:0] cur_base;
  int            cur_words, issued, dp_beat, dp_waits;
  int            stall_beat, stall_cycles, err_beat, err_phase;
  bit            rand_waits;
  int            pops_obs, done_obs, err_obs;

  task automatic model_reset();
    cmd_active = 0; err_mode = 0; done_now = 0; dp_pend = 0; gap = 1;
    issued = 0; cur_words = 0; dp_beat = 0; dp_waits = 0; err_phase = 0; err_beat = -1;
    HREADY = 1'b1; HRESP = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // then update FIFO and slave response just after the rising edge.
  task automatic step();
    bit first_err, dp_ok, exp_act, exp_ns, exp_busy, pop_seen, next_done;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_trans;
    @(negedge HCLK);
    first_err = dp_pend && !HREADY && HRESP;
    dp_ok     = dp_pend && HREADY && !HRESP;
    exp_busy  = cmd_active || err_mode;
    exp_act   = cmd_active && (issued < cur_words) && (fifo_q.size() != 0) && !first_err;
    exp_addr  = cur_base + 32'(issued) * 32'd4;
    exp_ns    = gap || (exp_addr[9:0] == 10'd0);
    exp_trans = !exp_act ? 2'b00 : (exp_ns ? 2'b10 : 2'b11);

    vectors++;
    if (HTRANS !== exp_trans) begin
      miscompares++;
      $display("FAIL htrans t=%0t got=%b want=%b", $time, HTRANS, exp_trans);
    end
    if (exp_act) begin
      vectors++;
      if (HADDR !== exp_addr) begin
        miscompares++;
        $display("FAIL haddr t=%0t got=%h want=%h", $time, HADDR, exp_addr);
      end
    end
    vectors++;
    if (fifo_rd_en !== (exp_act && HREADY)) begin
      miscompares++;
      $display("FAIL fifo_rd_en t=%0t got=%b want=%b", $time, fifo_rd_en, exp_act && HREADY);
    end
    if (dp_pend && HRESP !== 1'b1) begin
      vectors++;
      if (HWDATA !== pushed[dp_beat]) begin
        miscompares++;
        $display("FAIL hwdata t=%0t beat=%0d got=%h want=%h", $time, dp_beat, HWDATA, pushed[dp_beat]);
      end
    end
    vectors++;
    if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
      miscompares++;
      $display("FAIL busy_ready t=%0t got=%b/%b want=%b/%b", $time, busy, cmd_ready, exp_busy, !exp_busy);
    end
    vectors++;
    if (done !== done_now || err !== err_mode) begin
      miscompares++;
      $display("FAIL done_err t=%0t got=%b/%b want=%b/%b", $time, done, err, done_now, err_mode);
    end

    pop_seen = (fifo_rd_en === 1'b1);
    if (pop_seen) pops_obs++;
    if (done === 1'b1) done_obs++;
    if (err === 1'b1) err_obs++;

    next_done = 0;
    if (err_mode) begin
      err_mode = 0;
      dp_pend  = 0;
    end else if (first_err) begin
      err_mode   = 1;
      cmd_active = 0;
    end else begin
      if (cmd_active && !exp_act) gap = 1;
      if (dp_ok && dp_beat == cur_words - 1) begin
        next_done  = 1;
        cmd_active = 0;
      end
      if (exp_act && HREADY) begin
        dp_pend  = 1;
        dp_beat  = issued;
        dp_waits = (issued == stall_beat) ? stall_cycles :
                   (rand_waits ? int'($urandom_range(0, 2)) : 0);
        issued++;
        gap = 0;
      end else if (dp_ok) begin
        dp_pend = 0;
      end
    end
    if (cmd_valid && !exp_busy) begin
      cur_base  = {cmd_addr[AW-1:2], 2'b00};
      cur_words = int'(cmd_words);
      issued = 0; gap = 1; dp_pend = 0; err_phase = 0; cyc = 0;
      if (cmd_words == '0) next_done = 1;
      else cmd_active = 1;
    end
    done_now = next_done;

    @(posedge HCLK);
    #1;
    if (pop_seen && fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
    cyc++;
    if (cmd_active && cyc >= refill_delay) begin
      if (trickle) begin
        if (next_push < pushed.size() && $urandom_range(0, 1) == 1) begin
          fifo_q.push_back(pushed[next_push]);
          next_push++;
        end
      end else begin
        while (next_push < pushed.size()) begin
          fifo_q.push_back(pushed[next_push]);
          next_push++;
        end
      end
    end
    fifo_empty = (fifo_q.size() == 0);
    if (dp_pend && dp_beat == err_beat && err_phase == 0) begin
      HREADY = 1'b0; HRESP = 1'b1; err_phase = 1;
    end else if (dp_pend && err_phase == 1) begin
      HREADY = 1'b1; HRESP = 1'b1; err_phase = 2;
    end else if (dp_pend && dp_waits > 0) begin
      HREADY = 1'b0; HRESP = 1'b0; dp_waits--;
    end else begin
      HREADY = 1'b1; HRESP = 1'b0;
    end
  endtask

  task automatic start_cmd(input logic [AW-1:0] addr, input int words, input int preload,
                           input int rdelay, input bit trk, input int sbeat, input int scyc,
                           input bit rw, input int ebeat);
    fifo_q.delete();
    pushed.delete();
    for (int i = 0; i < words; i++) pushed.push_back($urandom);
    next_push = 0;
    while (next_push < preload && next_push < words) begin
      fifo_q.push_back(pushed[next_push]);
      next_push++;
    end
    fifo_empty   = (fifo_q.size() == 0);
    refill_delay = rdelay; trickle = trk; stall_beat = sbeat; stall_cycles = scyc;
    rand_waits   = rw; err_beat = ebeat;
    pops_obs = 0; done_obs = 0; err_obs = 0;
    cmd_addr = addr; cmd_words = CW'(words); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [AW-1:0] addr, input int words,
                         input int preload, input int rdelay, input bit trk, input int sbeat,
                         input int scyc, input bit rw, input int ebeat);
    int n;
    int exp_pops;
    start_cmd(addr, words, preload, rdelay, trk, sbeat, scyc, rw, ebeat);
    n = 0;
    while ((cmd_active || err_mode || done_now) && n < 1000) begin
      cmd_addr  = $urandom;      // ignored while busy
      cmd_words = CW'($urandom);
      step();
      n++;
    end
    if (n >= 1000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout after %0d cycles", name, n);
      model_reset();
    end
    step();
    exp_pops = (ebeat >= 0) ? ebeat + 1 : words;
    vectors++;
    if (pops_obs !== exp_pops) begin
      miscompares++;
      $display("FAIL %s pops got=%0d want=%0d", name, pops_obs, exp_pops);
    end
    vectors++;
    if (done_obs !== ((ebeat < 0) ? 1 : 0) || err_obs !== ((ebeat < 0) ? 0 : 1)) begin
      miscompares++;
      $display("FAIL %s pulses done=%0d err=%0d ebeat=%0d", name, done_obs, err_obs, ebeat);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (HTRANS !== 2'b00 || HADDR !== '0 || fifo_rd_en !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s htrans=%b haddr=%h rd=%b done=%b err=%b busy=%b ready=%b (want 00/0/0/0/0/0/1)",
               name, HTRANS, HADDR, fifo_rd_en, done, err, busy, cmd_ready);
    end
    vectors++;
    if (HWRITE !== 1'b1 || HSIZE !== 3'b010 || HBURST !== 3'b001) begin
      miscompares++;
      $display("FAIL %s consts hwrite=%b hsize=%b hburst=%b want 1/010/001", name, HWRITE, HSIZE, HBURST);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_words = '0;
    fifo_rdata = '0; fifo_empty = 1'b1;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_single_burst();
    run_cmd("single_burst", 32'h1000, 4, 4, 0, 0, -1, 0, 0, -1);
  endtask

  task automatic test_wait_states();
    run_cmd("wait_states", 32'h1000, 4, 4, 0, 0, 0, 2, 0, -1);
  endtask

  task automatic test_kb_boundary();
    run_cmd("kb_boundary", 32'h13F8, 4, 4, 0, 0, -1, 0, 0, -1);
  endtask

  task automatic test_fifo_gap();
    run_cmd("fifo_gap", 32'h2000, 3, 1, 3, 0, -1, 0, 0, -1);
  endtask

  task automatic test_error();
    run_cmd("error", 32'h3000, 4, 4, 0, 0, -1, 0, 0, 1);
  endtask

  task automatic test_zero_words();
    run_cmd("zero_words", 32'h4000, 0, 0, 0, 0, -1, 0, 0, -1);
  endtask

  task automatic test_misaligned_wrap();
    run_cmd("wrap", 32'hFFFF_FFFB, 4, 4, 0, 0, -1, 0, 0, -1);
  endtask

  task automatic test_reset_mid_burst();
    start_cmd(32'h5000, 8, 8, 0, 0, 2, 3, 0, -1);
    repeat (3) step();
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_burst");
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    step();
    run_cmd("after_reset", 32'h6000, 3, 3, 0, 0, -1, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 32'h7000, 2, 2, 0, 0, -1, 0, 0, -1);
    run_cmd("b2b_b", 32'h7100, 2, 0, 0, 1, -1, 0, 1, -1);
  endtask

  task automatic test_random();
    logic [AW-1:0] addr;
    int words, ebeat;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: addr = $urandom;
        1: addr = (32'($urandom_range(1, 1000)) << 10) - 32'($urandom_range(0, 7)) * 32'd4
                  + 32'($urandom_range(0, 3));
        2: addr = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
        default: addr = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
      endcase
      words = $urandom_range(0, 12);
      ebeat = (words > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, words - 1)) : -1;
      run_cmd("random", addr, words, $urandom_range(0, words), $urandom_range(0, 5),
              1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), ebeat);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wait_states();
    test_kb_boundary();
    test_fifo_gap();
    test_error();
    test_zero_words();
    test_misaligned_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
